// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares main memory between I/D line-fill bursts and write-through stores
// Optional: define MEM_ARB_ROUND_ROBIN_EN to alternate I/D fill grants when both are pending.
module mem_port_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int LINE_WORDS = 8,
  parameter int IDX_W      = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_fill_valid,
  output logic              i_done,
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  output logic              d_fill_valid,
  output logic              d_done,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  output logic [DATA_W-1:0] fill_data,
  output logic [IDX_W-1:0]  fill_word,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_enable,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rvalid,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, WRITE, FILL_I, FILL_D} state_t;

  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(LINE_WORDS - 1);
  localparam logic [ADDR_W-1:0] BASE_MASK = ~ADDR_W'((1 << (IDX_W + 1)) - 1);

  state_t              state, state_nx;
  logic [IDX_W-1:0]    issue_cnt, issue_cnt_nx;
  logic [IDX_W-1:0]    recv_cnt, recv_cnt_nx;
  logic                issuing, issuing_nx;
  logic [ADDR_W-1:0]   line_base, line_base_nx;
  logic                grant_d, grant_i;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // last_fill_d = 0 means the I-cache owned the most recent fill
  logic last_fill_d;

  assign grant_d = d_req && (!i_req || !last_fill_d);

  always_ff @(posedge clk) begin
    if (rst) begin
      last_fill_d <= 1'b0;
    end else if (state == IDLE && !wr_req && (d_req || i_req)) begin
      last_fill_d <= grant_d;
    end
  end
`else
  assign grant_d = d_req;
`endif

  assign grant_i   = i_req && !grant_d;
  assign busy      = (state != IDLE);
  assign fill_data = mem_rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      issue_cnt <= '0;
      recv_cnt  <= '0;
      issuing   <= 1'b0;
      line_base <= '0;
    end else begin
      state     <= state_nx;
      issue_cnt <= issue_cnt_nx;
      recv_cnt  <= recv_cnt_nx;
      issuing   <= issuing_nx;
      line_base <= line_base_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    issue_cnt_nx = issue_cnt;
    recv_cnt_nx  = recv_cnt;
    issuing_nx   = issuing;
    line_base_nx = line_base;
    mem_enable   = 1'b0;
    mem_wr       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    wr_ack       = 1'b0;
    i_fill_valid = 1'b0;
    d_fill_valid = 1'b0;
    i_done       = 1'b0;
    d_done       = 1'b0;
    fill_word    = '0;
    case (state)
      IDLE: begin
        issue_cnt_nx = '0;
        recv_cnt_nx  = '0;
        issuing_nx   = 1'b0;
        // stores first so a following fill of the same line sees the new data
        if (wr_req) begin
          state_nx = WRITE;
        end else if (grant_d) begin
          state_nx     = FILL_D;
          line_base_nx = d_addr & BASE_MASK;
          issuing_nx   = 1'b1;
        end else if (grant_i) begin
          state_nx     = FILL_I;
          line_base_nx = i_addr & BASE_MASK;
          issuing_nx   = 1'b1;
        end
      end
      WRITE: begin
        mem_enable = 1'b1;
        mem_wr     = 1'b1;
        mem_addr   = wr_addr;
        mem_wdata  = wr_data;
        wr_ack     = 1'b1;
        state_nx   = IDLE;
      end
      default: begin
        // issue and receive run independently; only mem_rvalid advances receive
        if (issuing) begin
          mem_enable   = 1'b1;
          mem_addr     = line_base | (ADDR_W'(issue_cnt) << 1);
          issue_cnt_nx = issue_cnt + 1'b1;
          if (issue_cnt == LAST_IDX) issuing_nx = 1'b0;
        end
        if (mem_rvalid) begin
          i_fill_valid = (state == FILL_I);
          d_fill_valid = (state == FILL_D);
          fill_word    = recv_cnt;
          recv_cnt_nx  = recv_cnt + 1'b1;
          if (recv_cnt == LAST_IDX) begin
            i_done   = (state == FILL_I);
            d_done   = (state == FILL_D);
            state_nx = IDLE;
          end
        end
      end
    endcase
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - randomized and directed checks of mem_port_arbiter against a transaction-level model
module tb_mem_port_arbiter;
  localparam int AW = 16, DW = 16, LW = 8, IW = 3;
  localparam logic [AW-1:0] LINE_MASK = 16'hFFF0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, i_req, d_req, wr_req;
  logic [AW-1:0] i_addr, d_addr, wr_addr;
  logic [DW-1:0] wr_data;
  logic i_fill_valid, i_done, d_fill_valid, d_done, wr_ack, mem_enable, mem_wr, busy;
  logic [DW-1:0] fill_data, mem_wdata, mem_rdata;
  logic [IW-1:0] fill_word;
  logic [AW-1:0] mem_addr;
  logic mem_rvalid;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LINE_WORDS(LW), .IDX_W(IW)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_fill_valid(i_fill_valid), .i_done(i_done),
    .d_req(d_req), .d_addr(d_addr), .d_fill_valid(d_fill_valid), .d_done(d_done),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .fill_data(fill_data), .fill_word(fill_word),
    .mem_addr(mem_addr), .mem_enable(mem_enable), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid), .busy(busy)
  );

  function automatic logic [DW-1:0] word_of(input logic [AW-1:0] a);
    return a ^ 16'h5A3C;
  endfunction

  // memory with latency 4: a read issued in cycle t returns in cycle t+3
  logic [2:0]    pv = '0;
  logic [AW-1:0] pa [3];
  logic          stray = 1'b0;
  always @(posedge clk) begin
    pv    <= {pv[1:0], mem_enable & ~mem_wr};
    pa[2] <= pa[1];
    pa[1] <= pa[0];
    pa[0] <= mem_addr;
  end
  assign mem_rvalid = pv[2] | stray;
  assign mem_rdata  = pv[2] ? word_of(pa[2]) : 16'hDEAD;

  int comps = 0, errs = 0, cyc = 0, dfv_cnt = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    comps++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  // model state: kind 0=idle 1=write 2=I fill 3=D fill
  int m_kind = 0, m_iss = 0, m_rcv = 0;
  logic [AW-1:0] m_base = '0;
  logic m_last_d = 1'b0, pick_d;
  logic e_en, e_wr, e_ack, e_ifv, e_dfv, e_id, e_dd, e_busy;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wd;
  logic [IW-1:0] e_fw;

  int addr_log[$], en_cyc_log[$], done_log[$], done_cyc_log[$], wr_cyc_log[$], busy_start_log[$];
  logic prev_busy = 1'b0;

  always @(negedge clk) begin
    e_en = 0; e_wr = 0; e_ack = 0; e_ifv = 0; e_dfv = 0; e_id = 0; e_dd = 0;
    e_addr = '0; e_wd = '0; e_fw = '0;
    e_busy = (m_kind != 0);
    if (m_kind == 1) begin
      e_en = 1; e_wr = 1; e_ack = 1; e_addr = wr_addr; e_wd = wr_data;
    end else if (m_kind >= 2) begin
      if (m_iss < LW) begin
        e_en = 1; e_addr = m_base + AW'(2 * m_iss);
      end
      if (mem_rvalid && m_rcv < LW) begin
        e_ifv = (m_kind == 2); e_dfv = (m_kind == 3);
        e_fw = IW'(m_rcv);
        e_id = e_ifv && (m_rcv == LW - 1);
        e_dd = e_dfv && (m_rcv == LW - 1);
      end
    end
    check("busy", busy, e_busy);
    check("mem_enable", mem_enable, e_en);
    check("mem_wr", mem_wr, e_wr);
    check("mem_addr", mem_addr, e_addr);
    check("mem_wdata", mem_wdata, e_wd);
    check("wr_ack", wr_ack, e_ack);
    check("i_fill_valid", i_fill_valid, e_ifv);
    check("d_fill_valid", d_fill_valid, e_dfv);
    check("i_done", i_done, e_id);
    check("d_done", d_done, e_dd);
    check("fill_word", fill_word, e_fw);
    check("fill_excl", i_fill_valid & d_fill_valid, 0);
    if (e_ifv || e_dfv) check("fill_data", fill_data, word_of(m_base + AW'(2 * m_rcv)));

    if (mem_enable && !mem_wr) begin addr_log.push_back(mem_addr); en_cyc_log.push_back(cyc); end
    if (mem_enable && mem_wr) wr_cyc_log.push_back(cyc);
    if (i_done) begin done_log.push_back(2); done_cyc_log.push_back(cyc); end
    if (d_done) begin done_log.push_back(3); done_cyc_log.push_back(cyc); end
    if (busy && !prev_busy) busy_start_log.push_back(cyc);
    if (d_fill_valid) dfv_cnt++;
    prev_busy = busy;

    if (rst) begin
      m_kind = 0; m_iss = 0; m_rcv = 0; m_last_d = 1'b0;
    end else if (m_kind == 0) begin
      if (wr_req) m_kind = 1;
      else if (d_req || i_req) begin
        pick_d = d_req && (!i_req || !RR || !m_last_d);
        m_kind = pick_d ? 3 : 2;
        m_last_d = pick_d;
        m_base = (pick_d ? d_addr : i_addr) & LINE_MASK;
        m_iss = 0; m_rcv = 0;
      end
    end else if (m_kind == 1) begin
      m_kind = 0;
    end else begin
      if (m_iss < LW) m_iss++;
      if (mem_rvalid && m_rcv < LW) begin
        m_rcv++;
        if (m_rcv == LW) m_kind = 0;
      end
    end
    cyc++;
  end

  bit i_hold = 0, d_hold = 0, rand_on = 0;

  task automatic tick();
    @(posedge clk); #1;
    if (e_ack) wr_req = 1'b0;
    if (e_id) i_req = i_hold;
    if (e_dd) d_req = d_hold;
    stray = rand_on && (m_kind < 2) && ($urandom_range(0, 3) == 0);
  endtask

  task automatic clear_logs();
    addr_log.delete(); en_cyc_log.delete(); done_log.delete();
    done_cyc_log.delete(); wr_cyc_log.delete(); busy_start_log.delete();
  endtask

  task automatic run_until_dones(input int k, input int bound);
    int n = 0;
    while (done_log.size() < k && n < bound) begin tick(); n++; end
    check("dones_timeout", done_log.size() >= k, 1);
  endtask

  task automatic drain(input int bound);
    int n = 0;
    while ((wr_req || i_req || d_req || m_kind != 0) && n < bound) begin tick(); n++; end
    check("drain_timeout", n < bound, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, snap;
    rst = 1; i_req = 0; d_req = 0; wr_req = 0;
    i_addr = '0; d_addr = '0; wr_addr = '0; wr_data = '0;
    tick(); tick();
    check("reset_busy", busy, 0);
    check("reset_mem_enable", mem_enable, 0);
    check("reset_mem_addr", mem_addr, 0);
    rst = 0;
    tick();

    // single I fill
    clear_logs();
    i_addr = 16'h1236; i_req = 1;
    run_until_dones(1, 40);
    tick();
    check("ifill_nwords", addr_log.size(), 8);
    if (addr_log.size() == 8) begin
      check("ifill_addr_first", addr_log[0], 16'h1230);
      check("ifill_addr_last", addr_log[7], 16'h123E);
      check("ifill_burst_span", en_cyc_log[7] - en_cyc_log[0], 7);
    end
    if (busy_start_log.size() > 0 && done_cyc_log.size() > 0)
      check("ifill_latency", done_cyc_log[0] - busy_start_log[0], 10);

    // simultaneous I and D: D first
    clear_logs();
    d_addr = 16'h0040; i_addr = 16'h0100; d_req = 1; i_req = 1;
    run_until_dones(2, 80);
    tick();
    if (done_log.size() == 2 && addr_log.size() == 16) begin
      check("sim_order0", done_log[0], 3);
      check("sim_order1", done_log[1], 2);
      check("sim_daddr", addr_log[0], 16'h0040);
      check("sim_iaddr", addr_log[8], 16'h0100);
      check("sim_gap", en_cyc_log[8] - done_cyc_log[0], 2);
    end else check("sim_nlog", addr_log.size(), 16);

    // store and D fill in the same cycle
    clear_logs();
    wr_addr = 16'h0050; wr_data = 16'hBEEF; d_addr = 16'h0200; wr_req = 1; d_req = 1;
    run_until_dones(1, 60);
    tick();
    if (wr_cyc_log.size() == 1 && en_cyc_log.size() > 0)
      check("coll_write_first", en_cyc_log[0] - wr_cyc_log[0], 2);
    else check("coll_nwrites", wr_cyc_log.size(), 1);

    // store arriving mid-fill waits for done
    clear_logs();
    d_addr = 16'h0220; d_req = 1;
    repeat (4) tick();
    wr_addr = 16'h0060; wr_data = 16'h1234; wr_req = 1;
    n = 0;
    while (wr_cyc_log.size() == 0 && n < 60) begin tick(); n++; end
    if (wr_cyc_log.size() == 1 && done_cyc_log.size() == 1)
      check("midfill_store_wait", wr_cyc_log[0] - done_cyc_log[0], 2);
    else check("midfill_store_seen", wr_cyc_log.size(), 1);
    drain(40);

    // reset mid-fill
    clear_logs();
    d_addr = 16'h0300; d_req = 1;
    n = 0;
    while (addr_log.size() < 3 && n < 20) begin tick(); n++; end
    rst = 1; d_req = 0;
    tick();
    rst = 0;
    check("rst_mid_busy", busy, 0);
    check("rst_mid_enable", mem_enable, 0);
    check("rst_mid_dfv", d_fill_valid, 0);
    snap = dfv_cnt;
    repeat (6) tick();
    check("rst_stray_dfv", dfv_cnt - snap, 0);
    check("rst_no_done", done_log.size(), 0);
    clear_logs();
    i_addr = 16'h0400; i_req = 1;
    run_until_dones(1, 40);
    tick();
    if (done_log.size() == 1 && addr_log.size() > 0) begin
      check("rst_next_owner", done_log[0], 2);
      check("rst_next_addr", addr_log[0], 16'h0400);
    end

    // continuous D misses with I pending
    clear_logs();
    d_hold = 1; i_hold = 1;
    d_addr = 16'h0500; i_addr = 16'h0600; d_req = 1; i_req = 1;
    run_until_dones(RR ? 4 : 3, 200);
    d_hold = 0; i_hold = 0; d_req = 0;
    for (int k = 0; k < (RR ? 4 : 3); k++)
      if (k < done_log.size()) check("arb_order", done_log[k], (RR && k % 2 == 1) ? 2 : 3);
    drain(100);

    // randomized traffic
    rand_on = 1;
    repeat (1500) begin
      tick();
      if (!wr_req && $urandom_range(0, 7) == 0) begin
        wr_req = 1; wr_addr = 16'($urandom); wr_data = 16'($urandom);
      end
      if (!d_req && $urandom_range(0, 5) == 0) begin d_req = 1; d_addr = 16'($urandom); end
      if (!i_req && $urandom_range(0, 5) == 0) begin i_req = 1; i_addr = 16'($urandom); end
    end
    rand_on = 0;
    drain(300);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", comps, errs);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single multicycle main memory between the I-cache fill FSM, the D-cache fill FSM and the write-through store path.
- Runs whole cache-line fills as pipelined bursts, one word issued per cycle, and routes returned words to the owning cache.
- Serialises single-word stores between bursts.
- Sits between the two cache controllers and the memory model; it replaces the ad-hoc request/enable glue in the top level.

Parameters:
- ADDR_W, 16, byte address width.
- DATA_W, 16, memory word width.
- LINE_WORDS, 8, words per cache line; must be a power of two.
- IDX_W, 3, log2(LINE_WORDS).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- i_req  in  1  I-cache line fill request; level, held until i_done
- i_addr  in  ADDR_W  I-cache miss address; line base = addr with low IDX_W+1 bits cleared
- i_fill_valid  out  1  returned word belongs to the I-cache
- i_done  out  1  one-cycle pulse with the last I-fill word
- d_req  in  1  D-cache line fill request; level, held until d_done
- d_addr  in  ADDR_W  D-cache miss address
- d_fill_valid  out  1  returned word belongs to the D-cache
- d_done  out  1  one-cycle pulse with the last D-fill word
- wr_req  in  1  store request; level, held until wr_ack
- wr_addr  in  ADDR_W  store address
- wr_data  in  DATA_W  store data
- wr_ack  out  1  one-cycle pulse when the store is issued
- fill_data  out  DATA_W  returned word; passes through mem_rdata
- fill_word  out  IDX_W  line index of the returned word
- mem_addr  out  ADDR_W  address to memory
- mem_enable  out  1  memory access strobe
- mem_wr  out  1  write strobe; qualified by mem_enable
- mem_wdata  out  DATA_W  store data to memory
- mem_rdata  in  DATA_W  memory read data
- mem_rvalid  in  1  memory read data valid
- busy  out  1  state is not IDLE

Behaviour:
- States: IDLE, WRITE, FILL_I, FILL_D.
- Reset (synchronous):
  - State goes to IDLE.
  - Issue and receive counters go to 0.
  - Every output is 0: strobes, valids, done, ack, busy, mem_addr, mem_wdata, fill_word.
  - A reset during a fill abandons the fill; no done pulse is produced.
- IDLE arbitration, registered, so the grant takes effect next cycle:
  - wr_req has priority over d_req, which has priority over i_req.
  - Stores win so that a later D fill of the same line observes the store.
  - Line base is latched on the grant.
- WRITE, exactly 1 cycle:
  - mem_enable=1, mem_wr=1, mem_addr=wr_addr, mem_wdata=wr_data, wr_ack=1.
  - Returns to IDLE.
- FILL_x issue phase:
  - issue_cnt runs 0..LINE_WORDS-1.
  - Each cycle: mem_enable=1, mem_wr=0, mem_addr = line_base | (issue_cnt<<1).
  - After LINE_WORDS cycles, mem_enable drops and the FSM stays in FILL_x.
- FILL_x receive phase:
  - On each mem_rvalid, x_fill_valid=1 and fill_word=recv_cnt; recv_cnt then increments.
  - No assumption is made about memory latency; only mem_rvalid is counted.
  - When recv_cnt==LINE_WORDS-1 and mem_rvalid=1: x_done=1 in the same cycle, and the state goes to IDLE next cycle.
  - Issue and receive phases overlap.
- Fill latency:
  - With memory latency L, one fill occupies 1+LINE_WORDS+L-1 cycles, counted from the grant cycle through done.
  - That is 12 cycles for L=4 and LINE_WORDS=8.
- Requests arriving during a fill or write wait; they are never dropped.
- Deasserting x_req mid-fill is illegal; the fill still completes and done still pulses.
- mem_rvalid seen in IDLE or WRITE is ignored: no valid, no counter change.
- i_fill_valid and d_fill_valid are never high together.
- mem_wr=1 never coincides with a FILL state.
- Back-to-back: done cycle, then IDLE for 1 cycle (arbitration), then the next grant. Minimum gap between a done and the next mem_enable is 1 cycle.
- Counters wrap modulo LINE_WORDS; line_base never changes during a fill.

Optional Feature:
- Macro: MEM_ARB_ROUND_ROBIN_EN.
- Defined:
  - A last_fill register (reset = I) tracks the most recent fill owner.
  - When d_req and i_req are both pending in IDLE with no wr_req, grant the one that did not own the last fill.
  - Stores keep top priority.
- Undefined: fixed priority wr > D > I; I may starve under continuous D misses.

Test Plan:
- Reset mid-fill: grant FILL_D, assert rst after 3 issued words -> next cycle all outputs 0 and busy=0; stray mem_rvalid produces no d_fill_valid; a new i_req is granted normally.
- Single I fill: i_addr=0x1236, L=4 memory model -> mem_addr 0x1230,0x1232,…,0x123E on 8 consecutive cycles; 8 i_fill_valid with fill_word 0..7; i_done on the 8th word, 12 cycles after the grant.
- Store/fill collision: wr_req and d_req asserted in the same cycle -> WRITE first (mem_wr=1, wr_ack one cycle), then FILL_D starts two cycles later; a store arriving mid-fill waits until the fill ends.
- Simultaneous I/D: i_req and d_req held from cycle 0, d_addr=0x0040, i_addr=0x0100 -> D fill completes first, then the I fill; no cycle has both fill_valids high.
- Round robin (macro defined): d_req held continuously with i_req pending -> fill order D, I, D, I. Macro undefined -> D, D, D while d_req is held.
